// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard and stall controller: load-use stalls, multi-cycle EX waits, ID redirects.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module ifid_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mc_start,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MC_W = $clog2(MC_LAT);
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LAT - 2);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t          state;
  logic [MC_W-1:0] mc_cnt;
  logic            lu_hazard;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign lu_hazard = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mc_start) begin
            state  <= MC_WAIT;
            mc_cnt <= MC_LOAD;
          end
        end
        MC_WAIT: begin
          if (mc_cnt == '0) state <= RUN;
          else              mc_cnt <= mc_cnt - MC_W'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  // NOTE: every output gets a default first, so no path through this block infers a latch.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    mc_busy      = 1'b0;
    if (!reset) begin
      if (state == MC_WAIT) begin
        // Redirects are ignored here; the branch stays in ID and resolves again on return.
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        mc_busy      = 1'b1;
      end else if (mc_start) begin
        // Start cycle of a multi-cycle op runs freely; the wait begins next cycle.
      end else if (lu_hazard) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (branch_taken || jump) begin
        if_id_flush  = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1))   stall_q <= stall_q + CNT_W'(1);
      if (if_id_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed testbench for ifid_hazard_ctrl (MC_LAT=4); counter checks follow HAZARD_PERF_CNT_EN.
module tb_ifid_hazard_ctrl;

  localparam int CNT_W = 32;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, mc_busy}
  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] MCW   = 5'b00011;
  localparam logic [4:0] FLUSH = 5'b10100;  // if_id_write is don't-care, masked out
  localparam logic [4:0] FMASK = 5'b10111;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_memread, mc_start, branch_taken, jump;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, mc_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  ifid_hazard_ctrl #(.MC_LAT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .mc_start(mc_start), .branch_taken(branch_taken), .jump(jump),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .mc_busy(mc_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, mc_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0;
    mc_start = 1'b0; branch_taken = 1'b0; jump = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_in();
    tick(); tick();
    // A live load-use condition must not stall while reset is held.
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL reset_forced: got %b expected %b", outs(), NORM);
    end
    tick();
    checks++;
    if ((stall_cnt !== '0) || (flush_cnt !== '0)) begin
      errors++; $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
    end
    clear_in();
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL reset_release: got %b expected %b", outs(), NORM);
    end
    tick();
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    checks++;
    if (outs() !== STALL) begin
      errors++; $display("FAIL lu_rs: got %b expected %b", outs(), STALL);
    end
    exp_stall++;
    tick();
    ex_memread = 1'b0;
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL lu_release: got %b expected %b", outs(), NORM);
    end
    tick();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
    #1;
    checks++;
    if (outs() !== STALL) begin
      errors++; $display("FAIL lu_rt: got %b expected %b", outs(), STALL);
    end
    exp_stall++;
    tick();
    clear_in();
  endtask

  task automatic test_zero_reg();
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL zero_reg: got %b expected %b", outs(), NORM);
    end
    tick();
    ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL rt_unused: got %b expected %b", outs(), NORM);
    end
    tick();
    clear_in();
  endtask

  task automatic test_multicycle();
    // mc_start together with a load-use hazard: mc_start wins, no stall this cycle.
    mc_start = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL mc_start_cycle: got %b expected %b", outs(), NORM);
    end
    tick();
    mc_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++;
      if (outs() !== MCW) begin
        errors++; $display("FAIL mc_wait_%0d: got %b expected %b", i, outs(), MCW);
      end
      exp_stall++;
      tick();
    end
    clear_in();
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL mc_return: got %b expected %b", outs(), NORM);
    end
    tick();
  endtask

  task automatic test_branch_in_mc();
    mc_start = 1'b1;
    tick();
    mc_start = 1'b0; branch_taken = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++;
      if (outs() !== MCW) begin
        errors++; $display("FAIL br_held_%0d: got %b expected %b", i, outs(), MCW);
      end
      exp_stall++;
      tick();
    end
    #1;
    checks++;
    if ((outs() & FMASK) !== FLUSH) begin
      errors++; $display("FAIL br_after_mc: got %b expected %b", outs() & FMASK, FLUSH);
    end
    exp_flush++;
    tick();
    clear_in();
  endtask

  task automatic test_jump();
    jump = 1'b1;
    #1;
    checks++;
    if ((outs() & FMASK) !== FLUSH) begin
      errors++; $display("FAIL jump_flush: got %b expected %b", outs() & FMASK, FLUSH);
    end
    exp_flush++;
    tick();
    ex_memread = 1'b1; ex_rt = 5'd12; id_rs = 5'd1; id_rt = 5'd12; id_uses_rt = 1'b1;
    #1;
    checks++;
    if (outs() !== STALL) begin
      errors++; $display("FAIL jump_lu: got %b expected %b", outs(), STALL);
    end
    exp_stall++;
    tick();
    clear_in();
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL jump_idle: got %b expected %b", outs(), NORM);
    end
    tick();
  endtask

  task automatic test_reset_mid_mc();
    int es, ef;
`ifdef HAZARD_PERF_CNT_EN
    es = exp_stall; ef = exp_flush;
`else
    es = 0; ef = 0;
`endif
    checks++;
    if ((stall_cnt !== CNT_W'(es)) || (flush_cnt !== CNT_W'(ef))) begin
      errors++; $display("FAIL counters: got stall=%0d flush=%0d expected %0d/%0d", stall_cnt, flush_cnt, es, ef);
    end
    mc_start = 1'b1;
    tick();
    mc_start = 1'b0;
    #1;
    checks++;
    if (outs() !== MCW) begin
      errors++; $display("FAIL rst_mc_first: got %b expected %b", outs(), MCW);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL rst_mc_forced: got %b expected %b", outs(), NORM);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL rst_mc_run: got %b expected %b", outs(), NORM);
    end
    checks++;
    if ((stall_cnt !== '0) || (flush_cnt !== '0)) begin
      errors++; $display("FAIL rst_mc_counters: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
    end
    tick();
    #1;
    checks++;
    if (outs() !== NORM) begin
      errors++; $display("FAIL rst_mc_stay_run: got %b expected %b", outs(), NORM);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_multicycle();
    test_branch_in_mc();
    test_jump();
    test_reset_mid_mc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
